// File: rtl/prbs7_checker.sv
// -----------------------------------------------------------------------------
// prbs7_checker
//
// Serial PRBS7 (x^7 + x^6 + 1) bit-error checker. It self-synchronises by
// loading received bits into a 7-bit sequence register (HUNT). After enough
// consecutive correct predictions it declares lock and lets the register
// free-run (LOCKED). Mismatches are then reported as errors. A run of
// consecutive mismatches drops it back to HUNT.
//
// Parameters
//   LOCK_CNT : consecutive qualified matches needed to lock (1..255)
//   LOSS_CNT : consecutive mismatches in LOCKED that force HUNT (1..255)
//   ERR_W    : width of the saturating error counter
//
// Ports
//   clk       : clock, all state on the rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : qualifies in_bit; the checker state holds while low
//   in_bit    : received serial bit
//   clear     : synchronous clear of err_count (applied before counting)
//   locked    : high while in LOCKED
//   err_pulse : one-cycle pulse per mismatched bit while LOCKED
//   err_count : saturating count of errors seen while LOCKED
// -----------------------------------------------------------------------------
module prbs7_checker #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [7:0]       LOCK_TARGET = 8'(LOCK_CNT);
    localparam logic [7:0]       LOSS_TARGET = 8'(LOSS_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_reg,     state_next;
    logic [6:0]       seq_reg,       seq_next;
    logic [2:0]       fill_reg,      fill_next;
    logic [7:0]       match_reg,     match_next;
    logic [7:0]       miss_reg,      miss_next;
    logic             err_pulse_reg, err_pulse_next;
    logic [ERR_W-1:0] err_count_reg, err_count_next;

    logic             predict_bit;
    logic             bit_match;
    logic             qualified;
    logic [ERR_W-1:0] err_base;

    // Predicted bit follows the recurrence b[n] = b[n-7] ^ b[n-6].
    assign predict_bit = seq_reg[6] ^ seq_reg[5];
    assign bit_match   = ~(in_bit ^ predict_bit);
    // An all-zero register is a fixed point of the recurrence, so it must
    // never count towards lock.
    assign qualified   = (fill_reg == 3'd7) && (seq_reg != 7'd0);
    // Clear takes effect first so an error in the same cycle yields 1.
    assign err_base    = clear ? '0 : err_count_reg;

    always_comb begin
        state_next     = state_reg;
        seq_next       = seq_reg;
        fill_next      = fill_reg;
        match_next     = match_reg;
        miss_next      = miss_reg;
        err_pulse_next = 1'b0;      // pulse always falls after one cycle
        err_count_next = err_base;

        if (in_valid) begin
            case (state_reg)
                ST_HUNT: begin
                    seq_next = {seq_reg[5:0], in_bit};
                    if (fill_reg != 3'd7) begin
                        fill_next = fill_reg + 3'd1;
                    end
                    if (qualified && bit_match) begin
                        if (match_reg + 8'd1 == LOCK_TARGET) begin
                            state_next = ST_LOCKED;
                            match_next = '0;
                            miss_next  = '0;
                        end else begin
                            match_next = match_reg + 8'd1;
                        end
                    end else begin
                        match_next = '0;
                    end
                end

                ST_LOCKED: begin
                    // Free-run on the regenerated sequence; in_bit is only
                    // compared, never loaded.
                    seq_next = {seq_reg[5:0], predict_bit};
                    if (!bit_match) begin
                        err_pulse_next = 1'b1;
                        if (err_base != ERR_MAX) begin
                            err_count_next = err_base + ERR_W'(1);
                        end
                        if (miss_reg + 8'd1 == LOSS_TARGET) begin
                            state_next = ST_HUNT;
                            match_next = '0;
                            miss_next  = '0;
                            fill_next  = '0;
                        end else begin
                            miss_next = miss_reg + 8'd1;
                        end
                    end else begin
                        miss_next = '0;
                    end
                end

                default: begin
                    state_next = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_HUNT;
            seq_reg       <= '0;
            fill_reg      <= '0;
            match_reg     <= '0;
            miss_reg      <= '0;
            err_pulse_reg <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            seq_reg       <= seq_next;
            fill_reg      <= fill_next;
            match_reg     <= match_next;
            miss_reg      <= miss_next;
            err_pulse_reg <= err_pulse_next;
            err_count_reg <= err_count_next;
        end
    end

    assign locked    = (state_reg == ST_LOCKED);
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_prbs7_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs7_checker
//
// Self-checking bench for prbs7_checker. Two instances share the stimulus:
// the default configuration and one with ERR_W = 3 for saturation. Expected
// behaviour comes from a queue-based reference model of the lock/error rules
// plus fixed expectations for lock point, error counts and reset.
// -----------------------------------------------------------------------------
module tb_prbs7_checker;

    localparam int LOCK_CNT = 16;
    localparam int LOSS_CNT = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit   = 1'b0;
    logic        clear    = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic        locked3, err_pulse3;
    logic [2:0]  err_count3;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_lock, m_pulse;
    int m_count, m_count3, m_fill, m_run, m_miss;
    bit hist[$];   // last 7 sequence bits, index 0 oldest
    bit tx_q[$];   // transmitter history, index 0 oldest

    prbs7_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .clear(clear), .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    prbs7_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .clear(clear), .locked(locked3), .err_pulse(err_pulse3), .err_count(err_count3)
    );

    always #5 clk = ~clk;

    // Next bit of the clean transmitted PRBS7 stream.
    function automatic bit tx_next();
        bit nb;
        nb = tx_q[0] ^ tx_q[1];
        tx_q.push_back(nb);
        void'(tx_q.pop_front());
        return nb;
    endfunction

    task automatic model_reset();
        m_lock = 0; m_pulse = 0; m_count = 0; m_count3 = 0;
        m_fill = 0; m_run = 0; m_miss = 0;
        hist.delete();
        for (int i = 0; i < 7; i++) hist.push_back(1'b0);
    endtask

    // One clock edge of the checker's rules, written over the bit history.
    task automatic model_clock(input bit v, input bit b, input bit clr);
        bit pred, good, qual;
        m_pulse = 0;
        if (clr) begin
            m_count  = 0;
            m_count3 = 0;
        end
        if (v) begin
            pred = hist[0] ^ hist[1];
            good = (b == pred);
            if (!m_lock) begin
                qual = 0;
                if (m_fill >= 7) begin
                    for (int i = 0; i < 7; i++) if (hist[i]) qual = 1;
                end
                hist.push_back(b);
                m_fill++;
                if (qual && good) m_run++;
                else m_run = 0;
                if (m_run == LOCK_CNT) begin
                    m_lock = 1; m_run = 0; m_miss = 0;
                end
            end else begin
                hist.push_back(pred);
                if (!good) begin
                    m_pulse = 1;
                    if (m_count < 65535) m_count++;
                    if (m_count3 < 7) m_count3++;
                    m_miss++;
                end else begin
                    m_miss = 0;
                end
                if (m_miss == LOSS_CNT) begin
                    m_lock = 0; m_run = 0; m_miss = 0; m_fill = 0;
                end
            end
            void'(hist.pop_front());
        end
    endtask

    // Apply one cycle of inputs; returns 1 ns after the sampling edge.
    task automatic drive(input bit v, input bit b, input bit clr);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        clear    = clr;
        @(posedge clk);
        model_clock(v, b, clr);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; in_bit = 0; clear = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL reset: locked=%0b pulse=%0b count=%0d required 0 0 0",
                     locked, err_pulse, err_count);
        end
        checks++;
        if (locked3 !== 1'b0 || err_count3 !== 3'd0) begin
            errors++;
            $display("FAIL reset_w3: locked=%0b count=%0d required 0 0", locked3, err_count3);
        end
        $display("test_reset done");
    endtask

    task automatic test_clean_lock();
        do_reset();
        for (int k = 1; k <= 80; k++) begin
            drive(1, tx_next(), 0);
            checks++;
            if (locked !== m_lock || err_pulse !== m_pulse || err_count !== 16'(m_count)) begin
                errors++;
                $display("FAIL clean_lock bit %0d: locked=%0b pulse=%0b count=%0d required %0b %0b %0d",
                         k, locked, err_pulse, err_count, m_lock, m_pulse, m_count);
            end
            checks++;
            if (locked !== (k >= 7 + LOCK_CNT) || err_pulse !== 1'b0 || err_count !== 16'd0) begin
                errors++;
                $display("FAIL clean_lock_point bit %0d: locked=%0b pulse=%0b count=%0d required %0b 0 0",
                         k, locked, err_pulse, err_count, (k >= 7 + LOCK_CNT));
            end
        end
        $display("test_clean_lock done: locked=%0b count=%0d", locked, err_count);
    endtask

    task automatic test_single_flip();
        bit b;
        do_reset();
        for (int k = 1; k <= 105; k++) begin
            b = tx_next();
            if (k == 100) b = ~b;
            drive(1, b, 0);
            checks++;
            if (locked !== m_lock || err_pulse !== m_pulse || err_count !== 16'(m_count)) begin
                errors++;
                $display("FAIL single_flip bit %0d: locked=%0b pulse=%0b count=%0d required %0b %0b %0d",
                         k, locked, err_pulse, err_count, m_lock, m_pulse, m_count);
            end
            if (k == 100 || k == 101) begin
                checks++;
                if (err_pulse !== (k == 100) || err_count !== 16'd1 || locked !== 1'b1) begin
                    errors++;
                    $display("FAIL single_flip_pulse bit %0d: pulse=%0b count=%0d locked=%0b required %0b 1 1",
                             k, err_pulse, err_count, locked, (k == 100));
                end
            end
        end
        $display("test_single_flip done: count=%0d", err_count);
    endtask

    task automatic test_burst_loss();
        do_reset();
        for (int k = 0; k < 40; k++) drive(1, tx_next(), 0);
        for (int j = 1; j <= 4; j++) begin
            drive(1, ~tx_next(), 0);
            checks++;
            if (err_pulse !== 1'b1 || err_count !== 16'(j) || locked !== (j < 4)) begin
                errors++;
                $display("FAIL burst_miss %0d: pulse=%0b count=%0d locked=%0b required 1 %0d %0b",
                         j, err_pulse, err_count, locked, j, (j < 4));
            end
        end
        for (int i = 1; i <= 30; i++) begin
            drive(1, tx_next(), 0);
            checks++;
            if (locked !== (i >= 7 + LOCK_CNT) || err_count !== 16'd4 || err_pulse !== 1'b0) begin
                errors++;
                $display("FAIL burst_relock bit %0d: locked=%0b count=%0d pulse=%0b required %0b 4 0",
                         i, locked, err_count, err_pulse, (i >= 7 + LOCK_CNT));
            end
            checks++;
            if (locked !== m_lock || err_count !== 16'(m_count)) begin
                errors++;
                $display("FAIL burst_model bit %0d: locked=%0b count=%0d required %0b %0d",
                         i, locked, err_count, m_lock, m_count);
            end
        end
        $display("test_burst_loss done: count=%0d", err_count);
    endtask

    task automatic test_all_zeros();
        do_reset();
        for (int k = 1; k <= 200; k++) begin
            drive(1, 1'b0, 0);
            checks++;
            if (locked !== 1'b0 || err_count !== 16'd0 || err_pulse !== 1'b0) begin
                errors++;
                $display("FAIL all_zeros bit %0d: locked=%0b count=%0d pulse=%0b required 0 0 0",
                         k, locked, err_count, err_pulse);
            end
        end
        $display("test_all_zeros done");
    endtask

    task automatic test_gaps();
        bit v;
        int nv;
        nv = 0;
        do_reset();
        for (int k = 1; k <= 150; k++) begin
            v = ($urandom_range(0, 1) == 1);
            if (v) begin
                drive(1, tx_next(), 0);
                nv++;
            end else begin
                drive(0, 1'($urandom_range(0, 1)), 0);
            end
            checks++;
            if (locked !== (nv >= 7 + LOCK_CNT) || err_pulse !== 1'b0 || err_count !== 16'd0) begin
                errors++;
                $display("FAIL gaps cyc %0d valid %0d: locked=%0b pulse=%0b count=%0d required %0b 0 0",
                         k, nv, locked, err_pulse, err_count, (nv >= 7 + LOCK_CNT));
            end
        end
        $display("test_gaps done: valid bits=%0d", nv);
    endtask

    task automatic test_clear_same_cycle();
        do_reset();
        for (int k = 0; k < 30; k++) drive(1, tx_next(), 0);
        for (int e = 1; e <= 9; e++) begin
            drive(1, ~tx_next(), 0);
            if (e == 1) begin
                drive(0, 1'b0, 0);
                checks++;
                if (err_pulse !== 1'b0 || err_count !== 16'd1) begin
                    errors++;
                    $display("FAIL pulse_gap: pulse=%0b count=%0d required 0 1", err_pulse, err_count);
                end
            end
            repeat (3) drive(1, tx_next(), 0);
        end
        checks++;
        if (err_count !== 16'd9 || locked !== 1'b1) begin
            errors++;
            $display("FAIL pre_clear: count=%0d locked=%0b required 9 1", err_count, locked);
        end
        drive(1, ~tx_next(), 1);
        checks++;
        if (err_count !== 16'd1 || err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL clear_with_error: count=%0d pulse=%0b required 1 1", err_count, err_pulse);
        end
        drive(1, tx_next(), 1);
        checks++;
        if (err_count !== 16'd0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL clear_plain: count=%0d pulse=%0b required 0 0", err_count, err_pulse);
        end
        $display("test_clear_same_cycle done");
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 30; k++) drive(1, tx_next(), 0);
        for (int e = 1; e <= 10; e++) begin
            drive(1, ~tx_next(), 0);
            checks++;
            if (err_count3 !== 3'(m_count3) || err_pulse3 !== 1'b1) begin
                errors++;
                $display("FAIL sat_step %0d: count3=%0d pulse3=%0b required %0d 1",
                         e, err_count3, err_pulse3, m_count3);
            end
            repeat (2) drive(1, tx_next(), 0);
        end
        checks++;
        if (err_count3 !== 3'd7 || err_count !== 16'd10 || locked3 !== 1'b1) begin
            errors++;
            $display("FAIL saturation: count3=%0d count=%0d locked3=%0b required 7 10 1",
                     err_count3, err_count, locked3);
        end
        $display("test_saturation done: count3=%0d count=%0d", err_count3, err_count);
    endtask

    task automatic test_random();
        bit v, b, clr;
        int burst;
        burst = 0;
        do_reset();
        for (int k = 1; k <= 1500; k++) begin
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 49) == 0);
            b   = 1'b0;
            if (v) begin
                b = tx_next();
                if (burst > 0) begin
                    b = ~b;
                    burst--;
                end else if ($urandom_range(0, 199) == 0) begin
                    burst = $urandom_range(3, 5);
                end else if ($urandom_range(0, 39) == 0) begin
                    b = ~b;
                end
            end
            drive(v, b, clr);
            checks++;
            if (locked !== m_lock || err_pulse !== m_pulse || err_count !== 16'(m_count) ||
                err_count3 !== 3'(m_count3)) begin
                errors++;
                $display("FAIL random cyc %0d: locked=%0b pulse=%0b count=%0d count3=%0d required %0b %0b %0d %0d",
                         k, locked, err_pulse, err_count, err_count3, m_lock, m_pulse, m_count, m_count3);
            end
        end
        $display("test_random done: count=%0d locked=%0b", err_count, locked);
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 30; k++) drive(1, tx_next(), 0);
        drive(1, ~tx_next(), 0);
        checks++;
        if (locked !== 1'b1 || err_pulse !== 1'b1 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL pre_async: locked=%0b pulse=%0b count=%0d required 1 1 1",
                     locked, err_pulse, err_count);
        end
        #3;
        rst_n = 0;
        #1;
        checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0 || err_count3 !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: locked=%0b pulse=%0b count=%0d count3=%0d required 0 0 0 0",
                     locked, err_pulse, err_count, err_count3);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 1; i <= 7 + LOCK_CNT; i++) begin
            drive(1, tx_next(), 0);
            checks++;
            if (locked !== (i == 7 + LOCK_CNT)) begin
                errors++;
                $display("FAIL async_relock bit %0d: locked=%0b required %0b",
                         i, locked, (i == 7 + LOCK_CNT));
            end
        end
        $display("test_async_reset done");
    endtask

    initial begin
        for (int i = 0; i < 7; i++) tx_q.push_back(1'b1);
        model_reset();
        test_reset();
        test_clean_lock();
        test_single_flip();
        test_burst_loss();
        test_all_zeros();
        test_gaps();
        test_clear_same_cycle();
        test_saturation();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
